relax_osc_cal_ctrl: RTL and testbench

RELAX_OSC_CAL_CTRL -- requirements
Module: relax_osc_cal_ctrl

---
 rtl/relax_osc_pkg.sv | 16 +
 rtl/relax_osc_edge_cnt.sv | 35 +++
 rtl/relax_osc_cal_ctrl.sv | 134 +++++++++++++
 tb/tb_relax_osc_cal_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/relax_osc_pkg.sv
// Shared types and default constants for the relaxation oscillator calibration controller.
package relax_osc_pkg;

  localparam int unsigned DEF_TRIM_W        = 6;
  localparam int unsigned DEF_CNT_W         = 12;
  localparam int unsigned DEF_GATE_CYCLES   = 1024;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE
  } cal_state_e;

endpackage

// File: rtl/relax_osc_edge_cnt.sv
// Synchronizes the raw oscillator, detects rising edges and counts them with saturation.
module relax_osc_edge_cnt
  import relax_osc_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_in,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] count
);

  // bits [1:0] form the 2-flop synchronizer, bit 2 holds the previous synchronized value
  logic [2:0] sync_q;
  logic       rise;

  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      count  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], osc_in};
      if (clear) begin
        count <= '0;
      end else if (count_en && rise && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/relax_osc_cal_ctrl.sv
// Successive-approximation trim calibration: settle, count oscillator edges over a gate window,
// then keep or clear the bit under test.
module relax_osc_cal_ctrl
  import relax_osc_pkg::*;
#(
  parameter int unsigned TRIM_W        = DEF_TRIM_W,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              osc_in,
  input  logic              cal_start,
  input  logic [CNT_W-1:0]  target,
  output logic [TRIM_W-1:0] trim,
  output logic [CNT_W-1:0]  count_last,
  output logic              busy,
  output logic              done,
  output logic              no_osc
);

  localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TRIM_W-1:0] TRIM_MSB = {1'b1, {(TRIM_W-1){1'b0}}};

  cal_state_e        state, state_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [TRIM_W-1:0] trim_nxt, mask, mask_nxt, trim_kept;
  logic [CNT_W-1:0]  target_q, target_nxt, count_last_nxt, edge_count;
  logic              busy_nxt, done_nxt, no_osc_nxt, cnt_clear, cnt_en;

  relax_osc_edge_cnt #(.CNT_W(CNT_W)) u_edge_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .osc_in   (osc_in),
    .clear    (cnt_clear),
    .count_en (cnt_en),
    .count    (edge_count)
  );

  assign cnt_en    = (state == ST_MEASURE);
  assign trim_kept = (count_last > target_q) ? (trim & ~mask) : trim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      timer      <= '0;
      trim       <= '0;
      mask       <= '0;
      target_q   <= '0;
      count_last <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      no_osc     <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      trim       <= trim_nxt;
      mask       <= mask_nxt;
      target_q   <= target_nxt;
      count_last <= count_last_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      no_osc     <= no_osc_nxt;
    end
  end

  // Dropping ena aborts immediately; trim keeps whatever value it had at that point.
  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    trim_nxt       = trim;
    mask_nxt       = mask;
    target_nxt     = target_q;
    count_last_nxt = count_last;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    no_osc_nxt     = no_osc;
    cnt_clear      = 1'b0;
    if (!ena) begin
      state_nxt = ST_IDLE;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cal_start) begin
            target_nxt = target;
            trim_nxt   = TRIM_MSB;
            mask_nxt   = TRIM_MSB;
            no_osc_nxt = 1'b0;
            busy_nxt   = 1'b1;
            timer_nxt  = TMR_W'(SETTLE_CYCLES - 1);
            state_nxt  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (timer == '0) begin
            cnt_clear = 1'b1;
            timer_nxt = TMR_W'(GATE_CYCLES - 1);
            state_nxt = ST_MEASURE;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        ST_MEASURE: begin
          if (timer == '0) begin
            count_last_nxt = edge_count;
            if (edge_count == '0) no_osc_nxt = 1'b1;
            state_nxt = ST_COMPARE;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        ST_COMPARE: begin
          if (mask[0]) begin
            trim_nxt  = trim_kept;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            trim_nxt  = trim_kept | (mask >> 1);
            mask_nxt  = mask >> 1;
            timer_nxt = TMR_W'(SETTLE_CYCLES - 1);
            state_nxt = ST_SETTLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relax_osc_cal_ctrl.sv
// Randomized bench: an oscillator plant reacts to trim, and a SAR reference model predicts each step.
module tb_relax_osc_cal_ctrl;

  localparam int TRIM_W  = 6;
  localparam int CNT_W   = 8;
  localparam int GATE    = 1024;
  localparam int SETTLE  = 16;
  localparam int PER     = SETTLE + GATE + 1;
  localparam int LAT     = 1 + TRIM_W * PER;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic              osc_in = 1'b0;
  logic              cal_start = 1'b0;
  logic [CNT_W-1:0]  target = '0;
  logic [TRIM_W-1:0] trim;
  logic [CNT_W-1:0]  count_last;
  logic              busy, done, no_osc;

  int tests = 0;
  int fails = 0;

  relax_osc_cal_ctrl #(
    .TRIM_W(TRIM_W), .CNT_W(CNT_W), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .osc_in     (osc_in),
    .cal_start  (cal_start),
    .target     (target),
    .trim       (trim),
    .count_last (count_last),
    .busy       (busy),
    .done       (done),
    .no_osc     (no_osc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: f = trim*4 edges per window, mode 1: dead oscillator, mode 2: toggles every clk
  function automatic int osc_edges(input logic [TRIM_W-1:0] t, input int mode);
    int raw;
    case (mode)
      0:       raw = int'(t) * 4;
      1:       raw = 0;
      default: raw = GATE / 2;
    endcase
    return (raw > CNT_MAX) ? CNT_MAX : raw;
  endfunction

  task automatic run_cal(input logic [CNT_W-1:0] tgt, input int mode, input bit spam,
                         input int spec_trim);
    logic [TRIM_W-1:0] acc;
    logic [TRIM_W-1:0] cand [TRIM_W];
    int exp_cnt [TRIM_W];
    int k, o, burst_n;
    bit done_early, exp_noosc;
    acc = '0;
    exp_noosc = 1'b0;
    for (int b = 0; b < TRIM_W; b++) begin
      cand[b] = acc | TRIM_W'(1 << (TRIM_W - 1 - b));
      exp_cnt[b] = osc_edges(cand[b], mode);
      if (exp_cnt[b] == 0) exp_noosc = 1'b1;
      if (exp_cnt[b] <= int'(tgt)) acc = cand[b];
    end
    target = tgt;
    burst_n = 0;
    done_early = 1'b0;
    for (int c = 0; c <= LAT; c++) begin
      k = (c >= 1) ? (c - 1) / PER : 0;
      o = (c >= 1) ? c - k * PER : 0;
      if (c == 1) begin
        check("busy_after_start", 32'(busy), 32'd1);
        check("no_osc_cleared", 32'(no_osc), 32'd0);
      end
      if (c >= 1 && c < LAT) begin
        if (o == 20) begin
          check($sformatf("trim_step%0d", k), 32'(trim), 32'(cand[k]));
          burst_n = int'(trim) * 4;
        end
        if (o == PER) check($sformatf("count_step%0d", k), 32'(count_last), 32'(exp_cnt[k]));
        if (done) done_early = 1'b1;
      end
      if (c == LAT) begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("done_early", 32'(done_early), 32'd0);
        check("final_trim", 32'(trim), 32'(acc));
        check("final_count", 32'(count_last), 32'(exp_cnt[TRIM_W-1]));
        check("final_no_osc", 32'(no_osc), 32'(exp_noosc));
        if (spec_trim >= 0) check("spec_trim", 32'(trim), 32'(spec_trim));
      end
      case (mode)
        0:       osc_in = (o >= 40) && (o < 40 + 2 * burst_n) && (((o - 40) % 2) == 0);
        1:       osc_in = 1'b0;
        default: osc_in = ((c % 2) == 1);
      endcase
      cal_start = (c == 0) || (spam && c > 1 && c < LAT - 10 && $urandom_range(0, 99) < 5);
      tick();
    end
    cal_start = 1'b0;
    osc_in = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (20) tick();
    check("trim_hold_idle", 32'(trim), 32'(acc));
  endtask

  initial begin
    bit seen_done, seen_busy;
    #2;
    check("rst_trim", 32'(trim), 32'd0);
    check("rst_count", 32'(count_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_no_osc", 32'(no_osc), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    repeat (3) tick();
    check("ena_low_idle", 32'(busy), 32'd0);
    ena = 1'b1;
    tick();

    $display("[TB] directed targets 128 and 100");
    run_cal(8'd128, 0, 1'b0, 32);
    run_cal(8'd100, 0, 1'b0, 25);

    $display("[TB] random target with repeated cal_start while busy");
    run_cal(8'($urandom_range(0, 255)), 0, 1'b1, -1);

    $display("[TB] dead oscillator and saturating oscillator");
    run_cal(8'($urandom_range(0, 255)), 1, 1'b0, 63);
    run_cal(8'd255, 2, 1'b0, 63);

    $display("[TB] random targets");
    for (int r = 0; r < 2; r++) run_cal(8'($urandom_range(0, 255)), 0, 1'b0, -1);

    $display("[TB] ena dropped mid-measure");
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    repeat (500) tick();
    ena = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_trim", 32'(trim), 32'd32);
    seen_done = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    check("abort_trim_hold", 32'(trim), 32'd32);
    ena = 1'b1;
    tick();

    $display("[TB] reset mid-settle");
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_trim", 32'(trim), 32'd0);
    check("mid_rst_count", 32'(count_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_no_osc", 32'(no_osc), 32'd0);
    #3;
    rst_n = 1'b1;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    check("post_rst_no_done", 32'(seen_done), 32'd0);
    check("post_rst_idle", 32'(seen_busy), 32'd0);
    check("post_rst_trim", 32'(trim), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
